// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed scanner for a NUM_DIGITS common-anode
// 7-segment display. A pending buffer absorbs load strobes and is applied to
// the display buffer only at the end of a frame, so a frame never mixes old
// and new digits. Each slot starts with one dark cycle to suppress ghosting.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0
// is always shown); without it every digit is always driven.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    upd_pending,
  output logic [3:0]              dig_4bits,
  input  logic [7:0]              seg7_code,
  output logic [7:0]              seg7,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]          scan_idx_q, scan_idx_d;
  logic [4*NUM_DIGITS-1:0]   disp_q, pend_q;
  logic [NUM_DIGITS-1:0]     disp_dp_q, pend_dp_q;
  logic                      pend_valid_q;
  logic [7:0]                seg7_q, seg7_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      tick, wrap, blank;

  // The decoder's dp bit is replaced by the display buffer's own dp.
  logic unused_seg7_dp;
  assign unused_seg7_dp = seg7_code[7];

  assign tick = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
  assign wrap = tick && (scan_idx_q == IDX_W'(NUM_DIGITS - 1));

  // Prescaler and slot index next-state.
  always_comb begin
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (tick) begin
      scan_idx_d = wrap ? '0 : scan_idx_q + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  run_zero;

  // upper_zero[i] is set when nibble i and every higher nibble are zero.
  always_comb begin
    upper_zero = '0;
    run_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero      = run_zero & (disp_q[4*i +: 4] == 4'd0);
      upper_zero[i] = run_zero;
    end
  end

  assign blank = (scan_idx_q != '0) && upper_zero[scan_idx_q] && !disp_dp_q[scan_idx_q];
`else
  assign blank = 1'b0;
`endif

  // Next segment/anode drive; dark on the first cycle of a slot, when
  // disabled, or when the slot is blanked.
  always_comb begin
    seg7_d = 8'hFF;
    an_d   = '1;
    if (en && (div_cnt_q != '0) && !blank) begin
      seg7_d = {~disp_dp_q[scan_idx_q], seg7_code[6:0]};
      an_d   = ~(NUM_DIGITS'(1) << scan_idx_q);
    end
  end

  // Counters, frame buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      scan_idx_q   <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg7_q       <= 8'hFF;
      an_q         <= '1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg7_q     <= seg7_d;
      an_q       <= an_d;
      // Transfer sees the pending contents from before this cycle's load.
      if (wrap && pend_valid_q) begin
        disp_q       <= pend_q;
        disp_dp_q    <= pend_dp_q;
        pend_valid_q <= 1'b0;
      end
      if (load) begin
        pend_q       <= digits_in;
        pend_dp_q    <= dp_in;
        pend_valid_q <= 1'b1;
      end
    end
  end

  assign upd_pending = pend_valid_q;
  assign dig_4bits   = disp_q[{scan_idx_q, 2'b00} +: 4];
  assign seg7        = seg7_q;
  assign an          = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=4) with an attached
// hex->7seg decoder and a frame-level reference model.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic         clk = 1'b0;
  logic         rst, en, load;
  logic [15:0]  digits_in;
  logic [3:0]   dp_in;
  logic         upd_pending;
  logic [3:0]   dig_4bits;
  logic [7:0]   seg7_code;
  logic [7:0]   seg7;
  logic [3:0]   an;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: position in frame plus the two buffers.
  int          t = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_dpd = '0, m_pdp = '0;
  logic        m_pv = 1'b0;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .upd_pending(upd_pending), .dig_4bits(dig_4bits),
    .seg7_code(seg7_code), .seg7(seg7), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  always_comb seg7_code = dec7(dig_4bits);

  function automatic bit m_blank(int idx);
`ifdef LEADING_ZERO_BLANK_EN
    return (idx > 0) && ((m_disp >> (4 * idx)) == 16'd0) && (m_dpd[idx] == 1'b0);
`else
    return idx < 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // One clock: predict outputs from the model, advance the model, compare.
  task automatic cycle();
    logic [7:0] es, code;
    logic [3:0] ea;
    int ph, idx;
    ph  = t % DIV;
    idx = (t / DIV) % N;
    es  = 8'hFF;
    ea  = 4'hF;
    if (!rst && en && ph != 0 && !m_blank(idx)) begin
      code    = dec7(m_disp[4*idx +: 4]);
      es      = {~m_dpd[idx], code[6:0]};
      ea[idx] = 1'b0;
    end
    if (rst) begin
      t = 0; m_disp = '0; m_dpd = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
    end else begin
      if (ph == DIV - 1 && idx == N - 1 && m_pv) begin
        m_disp = m_pend; m_dpd = m_pdp; m_pv = 1'b0;
      end
      if (load) begin
        m_pend = digits_in; m_pdp = dp_in; m_pv = 1'b1;
      end
      t = (t + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    idx = (t / DIV) % N;
    check("model_seg7", {24'd0, seg7}, {24'd0, es});
    check("model_an", {28'd0, an}, {28'd0, ea});
    check("model_upd", {31'd0, upd_pending}, {31'd0, m_pv});
    check("model_dig", {28'd0, dig_4bits}, {28'd0, m_disp[4*idx +: 4]});
  endtask

  task automatic run_to_frame_start();
    for (int k = 0; k < FRAME; k++) begin
      cycle();
      if (t == 0) break;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d; dp_in = p; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic [3:0][7:0] seg;
    logic [3:0]      lit;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int dark, alit, seen_a;
    logic [3:0] ea;

    tbl[0] = '{16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b1111};
    tbl[1] = '{16'h1234, 4'b0010, {8'hF9, 8'hA4, 8'h30, 8'h99}, 4'b1111};
    tbl[3] = '{16'h89EF, 4'b1000, {8'h00, 8'h90, 8'h86, 8'h8E}, 4'b1111};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[2] = '{16'h0070, 4'b0000, {8'hFF, 8'hFF, 8'hF8, 8'hC0}, 4'b0011};
    tbl[4] = '{16'h0000, 4'b0100, {8'hFF, 8'h40, 8'hFF, 8'hC0}, 4'b0101};
`else
    tbl[2] = '{16'h0070, 4'b0000, {8'hC0, 8'hC0, 8'hF8, 8'hC0}, 4'b1111};
    tbl[4] = '{16'h0000, 4'b0100, {8'hC0, 8'h40, 8'hC0, 8'hC0}, 4'b1111};
`endif

    rst = 1'b1; en = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
    #2;
    cycle();
    cycle();
    check("reset_seg7", {24'd0, seg7}, 32'hFF);
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_upd", {31'd0, upd_pending}, 32'd0);
    rst = 1'b0;
    cycle();
    check("release_dark", {28'd0, an}, 32'hF);
    cycle();
    check("release_lit", {28'd0, an}, 32'hE);

    // Table: load at frame start, let it transfer, then inspect every slot.
    foreach (tbl[e]) begin
      run_to_frame_start();
      do_load(tbl[e].digits, tbl[e].dp);
      check("tbl_pending", {31'd0, upd_pending}, 32'd1);
      run_to_frame_start();
      check("tbl_applied", {31'd0, upd_pending}, 32'd0);
      for (int s = 0; s < N; s++) begin
        cycle();
        check("tbl_guard_an", {28'd0, an}, 32'hF);
        cycle();
        ea = 4'hF;
        if (tbl[e].lit[s]) ea[s] = 1'b0;
        check("tbl_an", {28'd0, an}, {28'd0, ea});
        check("tbl_seg7", {24'd0, seg7}, {24'd0, tbl[e].seg[s]});
        check("tbl_dig", {28'd0, dig_4bits}, {28'd0, tbl[e].digits[4*s +: 4]});
        cycle();
        cycle();
      end
    end

    // Last write wins within a frame; also one dark cycle per slot.
    run_to_frame_start();
    do_load(16'hAAAA, 4'b0000);
    for (int k = 0; k < 5; k++) cycle();
    do_load(16'h5555, 4'b0000);
    run_to_frame_start();
    dark = 0; seen_a = 0; alit = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle();
      if (an == 4'hF) dark++;
      if (dig_4bits == 4'hA) seen_a++;
      if (k == 5 && an == 4'b1101) alit++;
      if (k == 9 && an == 4'b1011) alit++;
      if (k == 13 && an == 4'b0111) alit++;
    end
    check("frame_dark_count", dark, 32'd8);
    check("overwritten_never_shown", seen_a, 32'd0);
    check("lit_order", alit, 32'd3);

    // Load on the wrap tick: old pending transfers, new one stays pending.
    run_to_frame_start();
    do_load(16'h1111, 4'b0000);
    for (int k = 0; k < FRAME - 2; k++) cycle();
    do_load(16'h2222, 4'b0000);
    check("wrap_load_pending", {31'd0, upd_pending}, 32'd1);
    check("wrap_load_old_shown", {28'd0, dig_4bits}, 32'h1);
    run_to_frame_start();
    check("wrap_load_new_shown", {28'd0, dig_4bits}, 32'h2);
    check("wrap_load_cleared", {31'd0, upd_pending}, 32'd0);

    // Display disabled: anodes stay off for a full frame.
    en = 1'b0;
    alit = 0;
    for (int k = 0; k < FRAME; k++) begin
      cycle();
      if (an != 4'hF) alit++;
    end
    check("disabled_dark", alit, 32'd0);
    en = 1'b1;

    // Mid-frame reset drops pending data.
    do_load(16'h3333, 4'b1111);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midreset_upd", {31'd0, upd_pending}, 32'd0);
    check("midreset_dig", {28'd0, dig_4bits}, 32'h0);
    check("midreset_seg7", {24'd0, seg7}, 32'hFF);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      load      = ($urandom_range(0, 7) == 0);
      digits_in = 16'($urandom);
      dp_in     = 4'($urandom);
      en        = ($urandom_range(0, 9) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0; load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
